// File: rtl/mole_pkg.sv
// Shared types and helpers for the whack-a-mole round controller.
// Combinational definitions only: no latency, no flow control.
package mole_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SPAWN,
        ACTIVE,
        HIT_SHOW,
        GAP,
        OVER
    } state_t;

    localparam logic [4:0] POS_NONE = 5'd0;
    localparam logic [4:0] POS_Q    = 5'd1;
    localparam logic [4:0] POS_W    = 5'd2;
    localparam logic [4:0] POS_E    = 5'd3;
    localparam logic [4:0] POS_A    = 5'd4;
    localparam logic [4:0] POS_S    = 5'd5;
    localparam logic [4:0] POS_D    = 5'd6;
    localparam logic [4:0] POS_Z    = 5'd7;
    localparam logic [4:0] POS_X    = 5'd8;
    localparam logic [4:0] POS_C    = 5'd9;

    function automatic logic is_valid_pos(input logic [4:0] p);
        return (p >= POS_Q) && (p <= POS_C);
    endfunction

endpackage

// File: rtl/pos_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) stepping every cycle out of reset.
// One cycle per step; free-running, no backpressure.
module pos_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] state
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= SEED;
        end else begin
            state <= {state[6:0], state[7] ^ state[5] ^ state[4] ^ state[3]};
        end
    end

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole round controller: spawns enemies, judges key presses, keeps score/misses.
// All outputs registered (one cycle after the causing edge); no backpressure, pulses are never held.
module mole_scheduler
    import mole_pkg::*;
#(
    parameter int         ACTIVE_TICKS = 50,
    parameter int         HIT_TICKS    = 10,
    parameter int         GAP_TICKS    = 5,
    parameter int         MAX_MISS     = 3,
    parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       start,
    input  logic       key_valid,
    input  logic [4:0] key_pos,
    output logic [4:0] pos,
    output logic       hit,
    output logic [7:0] score,
    output logic [3:0] misses,
    output logic       game_over,
    output logic       busy
);

    state_t     state, state_n;
    logic [7:0] tcnt, tcnt_n;
    logic [4:0] last_pos, last_n;
    logic [4:0] pos_n;
    logic       hit_n;
    logic [7:0] score_n;
    logic [3:0] misses_n;
    logic       miss_inc;
    logic [7:0] lfsr;
    logic [4:0] cand;
    logic       lfsr_unused;

    pos_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .state (lfsr)
    );

    assign cand        = {1'b0, lfsr[3:0]};
    assign lfsr_unused = ^lfsr[7:4];

    always_comb begin
        state_n  = state;
        pos_n    = pos;
        hit_n    = hit;
        score_n  = score;
        misses_n = misses;
        last_n   = last_pos;
        miss_inc = 1'b0;

        case (state)
            IDLE: begin
                pos_n = POS_NONE;
                hit_n = 1'b0;
                if (start) begin
                    score_n  = 8'd0;
                    misses_n = 4'd0;
                    state_n  = SPAWN;
                end
            end
            SPAWN: begin
                if (is_valid_pos(cand) && (cand != last_pos)) begin
                    pos_n   = cand;
                    last_n  = cand;
                    state_n = ACTIVE;
                end
            end
            ACTIVE: begin
                hit_n = 1'b0;
                // A correct key wins over a timeout landing on the same cycle.
                if (key_valid && (key_pos == pos)) begin
                    score_n = (score == 8'hFF) ? score : score + 8'd1;
                    hit_n   = 1'b1;
                    state_n = HIT_SHOW;
                end else if (key_valid && is_valid_pos(key_pos)) begin
                    miss_inc = 1'b1;
                end else if (tick && (tcnt == 8'(ACTIVE_TICKS - 1))) begin
                    miss_inc = 1'b1;
                    pos_n    = POS_NONE;
                    state_n  = GAP;
                end
                if (miss_inc) begin
                    misses_n = misses + 4'd1;
                    if (misses_n == 4'(MAX_MISS)) begin
                        pos_n   = POS_NONE;
                        hit_n   = 1'b0;
                        state_n = OVER;
                    end
                end
            end
            HIT_SHOW: begin
                if (tick && (tcnt == 8'(HIT_TICKS - 1))) begin
                    pos_n   = POS_NONE;
                    hit_n   = 1'b0;
                    state_n = GAP;
                end
            end
            GAP: begin
                pos_n = POS_NONE;
                if (tick && (tcnt == 8'(GAP_TICKS - 1))) begin
                    state_n = SPAWN;
                end
            end
            OVER: begin
                pos_n = POS_NONE;
                hit_n = 1'b0;
                if (start) begin
                    score_n  = 8'd0;
                    misses_n = 4'd0;
                    state_n  = SPAWN;
                end
            end
            default: begin
                pos_n   = POS_NONE;
                hit_n   = 1'b0;
                state_n = IDLE;
            end
        endcase

        if (state_n != state) begin
            tcnt_n = 8'd0;
        end else if (tick) begin
            tcnt_n = tcnt + 8'd1;
        end else begin
            tcnt_n = tcnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            tcnt      <= 8'd0;
            last_pos  <= POS_NONE;
            pos       <= POS_NONE;
            hit       <= 1'b0;
            score     <= 8'd0;
            misses    <= 4'd0;
            game_over <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            tcnt      <= tcnt_n;
            last_pos  <= last_n;
            pos       <= pos_n;
            hit       <= hit_n;
            score     <= score_n;
            misses    <= misses_n;
            game_over <= (state_n == OVER);
            busy      <= (state_n != IDLE) && (state_n != OVER);
        end
    end

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed self-checking bench for mole_scheduler with short tick parameters (4/2/1, 3 misses).
module tb_mole_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       key_valid = 1'b0;
    logic [4:0] key_pos = 5'd0;
    logic [4:0] pos;
    logic       hit;
    logic [7:0] score;
    logic [3:0] misses;
    logic       game_over;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    mole_scheduler #(
        .ACTIVE_TICKS (4),
        .HIT_TICKS    (2),
        .GAP_TICKS    (1),
        .MAX_MISS     (3),
        .LFSR_SEED    (8'hA5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .start     (start),
        .key_valid (key_valid),
        .key_pos   (key_pos),
        .pos       (pos),
        .hit       (hit),
        .score     (score),
        .misses    (misses),
        .game_over (game_over),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // One clock: drive inputs, take the edge, sample 1 ns later, drop pulses.
    task automatic step(input logic t, input logic kv, input logic [4:0] kp, input logic s);
        tick = t; key_valid = kv; key_pos = kp; start = s;
        @(posedge clk);
        #1;
        tick = 1'b0; key_valid = 1'b0; key_pos = 5'd0; start = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic wait_pos(input string name, output logic [4:0] p);
        int n = 0;
        while (pos == 5'd0 && n < 60) begin
            idle();
            n++;
        end
        n_cmp++;
        if (pos === 5'd0) begin
            n_bad++;
            $display("FAIL %s: pos still 0 after %0d cycles, required nonzero", name, n);
        end
        p = pos;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) idle();
        n_cmp++; if (pos !== 5'd0) begin n_bad++; $display("FAIL reset_pos: got %0d want 0", pos); end
        n_cmp++; if (hit !== 1'b0) begin n_bad++; $display("FAIL reset_hit: got %0b want 0", hit); end
        n_cmp++; if (score !== 8'd0) begin n_bad++; $display("FAIL reset_score: got %0d want 0", score); end
        n_cmp++; if (misses !== 4'd0) begin n_bad++; $display("FAIL reset_misses: got %0d want 0", misses); end
        n_cmp++; if (game_over !== 1'b0) begin n_bad++; $display("FAIL reset_game_over: got %0b want 0", game_over); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            idle();
            n_cmp++;
            if ({pos, hit, score, misses, game_over, busy} !== 20'd0) begin
                n_bad++;
                $display("FAIL idle_quiet[%0d]: pos=%0d hit=%0b score=%0d misses=%0d go=%0b busy=%0b want all 0",
                         i, pos, hit, score, misses, game_over, busy);
            end
        end
    endtask

    task automatic test_hit_path();
        logic [4:0] p, q;
        step(1'b0, 1'b0, 5'd0, 1'b1);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL start_busy: got %0b want 1", busy); end
        wait_pos("hit_first_spawn", p);
        step(1'b0, 1'b1, p, 1'b0);
        n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL hit_flag: got %0b want 1", hit); end
        n_cmp++; if (score !== 8'd1) begin n_bad++; $display("FAIL hit_score: got %0d want 1", score); end
        n_cmp++; if (pos !== p) begin n_bad++; $display("FAIL hit_pos_held: got %0d want %0d", pos, p); end
        step(1'b1, 1'b0, 5'd0, 1'b0);
        n_cmp++; if ({pos, hit} !== {p, 1'b1}) begin n_bad++; $display("FAIL hit_show_tick1: pos=%0d hit=%0b want pos=%0d hit=1", pos, hit, p); end
        step(1'b1, 1'b0, 5'd0, 1'b0);
        n_cmp++; if ({pos, hit} !== 6'd0) begin n_bad++; $display("FAIL hit_show_end: pos=%0d hit=%0b want 0/0", pos, hit); end
        step(1'b1, 1'b0, 5'd0, 1'b0);
        wait_pos("hit_second_spawn", q);
        n_cmp++; if (q < 5'd1 || q > 5'd9) begin n_bad++; $display("FAIL respawn_range: got %0d want 1..9", q); end
        n_cmp++; if (q === p) begin n_bad++; $display("FAIL respawn_repeat: got %0d want != %0d", q, p); end
    endtask

    task automatic test_timeout();
        logic [4:0] p;
        for (int m = 1; m <= 3; m++) begin
            repeat (3) step(1'b1, 1'b0, 5'd0, 1'b0);
            n_cmp++; if (pos === 5'd0) begin n_bad++; $display("FAIL timeout_early[%0d]: pos=0 want nonzero", m); end
            step(1'b1, 1'b0, 5'd0, 1'b0);
            n_cmp++; if (pos !== 5'd0) begin n_bad++; $display("FAIL timeout_pos[%0d]: got %0d want 0", m, pos); end
            n_cmp++; if (misses !== 4'(m)) begin n_bad++; $display("FAIL timeout_misses[%0d]: got %0d want %0d", m, misses, m); end
            if (m < 3) begin
                n_cmp++; if (game_over !== 1'b0) begin n_bad++; $display("FAIL early_over[%0d]: got %0b want 0", m, game_over); end
                step(1'b1, 1'b0, 5'd0, 1'b0);
                wait_pos("timeout_respawn", p);
            end
        end
        n_cmp++; if ({game_over, busy} !== 2'b10) begin n_bad++; $display("FAIL over_flags: go=%0b busy=%0b want 1/0", game_over, busy); end
        step(1'b1, 1'b1, 5'd3, 1'b0);
        repeat (4) idle();
        n_cmp++; if ({pos, score, misses, game_over} !== {5'd0, 8'd1, 4'd3, 1'b1}) begin
            n_bad++; $display("FAIL over_frozen: pos=%0d score=%0d misses=%0d go=%0b want 0/1/3/1", pos, score, misses, game_over);
        end
        step(1'b0, 1'b0, 5'd0, 1'b1);
        n_cmp++; if ({score, misses, game_over, busy} !== {8'd0, 4'd0, 1'b0, 1'b1}) begin
            n_bad++; $display("FAIL restart: score=%0d misses=%0d go=%0b busy=%0b want 0/0/0/1", score, misses, game_over, busy);
        end
        wait_pos("restart_spawn", p);
    endtask

    task automatic test_wrong_key();
        logic [4:0] p, w;
        p = pos;
        w = (p == 5'd2) ? 5'd5 : 5'd2;
        step(1'b0, 1'b1, w, 1'b0);
        n_cmp++; if ({pos, hit, misses} !== {p, 1'b0, 4'd1}) begin n_bad++; $display("FAIL wrong_key: pos=%0d hit=%0b misses=%0d want %0d/0/1", pos, hit, misses, p); end
        step(1'b0, 1'b1, 5'd0, 1'b0);
        n_cmp++; if ({pos, hit, misses} !== {p, 1'b0, 4'd1}) begin n_bad++; $display("FAIL key_zero: pos=%0d hit=%0b misses=%0d want %0d/0/1", pos, hit, misses, p); end
        step(1'b0, 1'b1, 5'd12, 1'b0);
        n_cmp++; if ({pos, hit, misses} !== {p, 1'b0, 4'd1}) begin n_bad++; $display("FAIL key_twelve: pos=%0d hit=%0b misses=%0d want %0d/0/1", pos, hit, misses, p); end
        repeat (3) step(1'b1, 1'b0, 5'd0, 1'b0);
        step(1'b1, 1'b1, p, 1'b0);
        n_cmp++; if ({pos, hit, score, misses} !== {p, 1'b1, 8'd1, 4'd1}) begin
            n_bad++; $display("FAIL collision: pos=%0d hit=%0b score=%0d misses=%0d want %0d/1/1/1", pos, hit, score, misses, p);
        end
        repeat (3) step(1'b1, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic test_saturation();
        logic [4:0] p;
        int exp_score = 1;
        for (int i = 0; i < 260; i++) begin
            wait_pos("sat_spawn", p);
            repeat ($urandom_range(0, 3)) idle();
            step(1'b0, 1'b1, p, 1'b0);
            exp_score = (exp_score < 255) ? exp_score + 1 : 255;
            n_cmp++; if (score !== 8'(exp_score)) begin n_bad++; $display("FAIL sat_score[%0d]: got %0d want %0d", i, score, exp_score); end
            if (i < 259) repeat (3) step(1'b1, 1'b0, 5'd0, 1'b0);
        end
        n_cmp++; if ({hit, misses} !== {1'b1, 4'd1}) begin n_bad++; $display("FAIL sat_state: hit=%0b misses=%0d want 1/1", hit, misses); end
        rst_n = 1'b0;
        idle();
        n_cmp++;
        if ({pos, hit, score, misses, game_over, busy} !== 20'd0) begin
            n_bad++;
            $display("FAIL midgame_reset: pos=%0d hit=%0b score=%0d misses=%0d go=%0b busy=%0b want all 0",
                     pos, hit, score, misses, game_over, busy);
        end
        rst_n = 1'b1;
        repeat (3) idle();
        n_cmp++; if ({pos, busy} !== 6'd0) begin n_bad++; $display("FAIL post_reset_idle: pos=%0d busy=%0b want 0/0", pos, busy); end
    endtask

    task automatic test_spawn_dist();
        logic [4:0] p;
        logic [4:0] prev = 5'd0;
        int seen [10];
        foreach (seen[k]) seen[k] = 0;
        step(1'b0, 1'b0, 5'd0, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            wait_pos("dist_spawn", p);
            n_cmp++; if (p < 5'd1 || p > 5'd9) begin n_bad++; $display("FAIL dist_range[%0d]: got %0d want 1..9", i, p); end
            n_cmp++; if (p === prev) begin n_bad++; $display("FAIL dist_repeat[%0d]: got %0d want != %0d", i, p, prev); end
            if (p >= 5'd1 && p <= 5'd9) seen[p]++;
            prev = p;
            repeat ($urandom_range(0, 3)) idle();
            step(1'b0, 1'b1, p, 1'b0);
            repeat (3) step(1'b1, 1'b0, 5'd0, 1'b0);
        end
        for (int k = 1; k <= 9; k++) begin
            n_cmp++; if (seen[k] == 0) begin n_bad++; $display("FAIL dist_cover: position %0d seen 0 times, want >0", k); end
        end
    endtask

    initial begin
        test_reset();
        test_hit_path();
        test_timeout();
        test_wrong_key();
        test_saturation();
        test_spawn_dist();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mole_scheduler.md
Name: mole_scheduler

Overview:
- Round controller for the 3x3 whack-a-mole field (keys Q W E / A S D / Z X C, positions 1..9, 0 = no enemy).
- Decides when and where an enemy appears, how long it stays, and whether the player's key press hits it.
- Drives the `pos`/`hit` pair consumed by the enemy sprite-addressing logic.
- Keeps score and miss count, and ends the game after a fixed number of misses.

Parameters:
- ACTIVE_TICKS, 50: ticks an enemy stays up before counting as a miss.
- HIT_TICKS, 10: ticks the hit enemy stays displayed with `hit`=1.
- GAP_TICKS, 5: ticks with an empty field between enemies.
- MAX_MISS, 3: miss count that ends the game (range 1..15).
- LFSR_SEED, 8'hA5: reset value of the position LFSR (must be non-zero).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- tick  in  1  one-cycle timebase enable pulse (e.g. 10 ms), asynchronous to game events
- start  in  1  one-cycle pulse: begin or restart a game
- key_valid  in  1  one-cycle pulse: a key was pressed
- key_pos  in  5  pressed key position 1..9; other values are ignored
- pos  out  5  current enemy position 0..9 (0 = none)
- hit  out  1  1 while the current enemy is in the hit display
- score  out  8  hits this game, saturates at 255
- misses  out  4  misses this game
- game_over  out  1  1 in OVER state
- busy  out  1  1 in any state other than IDLE and OVER

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset values while `rst_n`=0 at a clk edge: state=IDLE, pos=0, hit=0, score=0, misses=0, game_over=0, busy=0, tick counter=0, last_pos=0, LFSR=LFSR_SEED. Reset mid-game aborts immediately; no residual outputs.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Advances every clock cycle in all states except reset, so player timing adds entropy.
- All outputs are registered.
- tcnt: 8-bit tick counter. Cleared on every state entry; increments only when tick=1.
- States:
  - IDLE: pos=0. start → SPAWN next cycle; score and misses cleared on that edge.
  - SPAWN: candidate c = LFSR[3:0].
    - Accept if 1<=c<=9 and c != last_pos; otherwise retry next cycle (no tick dependence).
    - On accept: pos<=c, last_pos<=c, → ACTIVE. pos is visible the cycle after the accept edge.
  - ACTIVE: pos held, hit=0. Evaluated in this priority order:
    1. key_valid && key_pos==pos → score<=sat(score+1), hit<=1, → HIT_SHOW. hit is visible the cycle after key_valid.
    2. key_valid && key_pos in 1..9 && key_pos!=pos → wrong key: misses+1, stay ACTIVE, tcnt not cleared.
    3. tick && tcnt==ACTIVE_TICKS-1 → timeout: misses+1, pos<=0, → GAP.
    - A correct key and a timeout in the same cycle count as a hit.
    - key_pos of 0 or 10..31 is ignored.
  - Miss limit: if any miss increment makes misses==MAX_MISS → OVER instead of the listed next state; pos<=0, hit<=0.
  - HIT_SHOW: pos held, hit=1. Keys ignored. tick && tcnt==HIT_TICKS-1 → pos<=0, hit<=0, → GAP.
  - GAP: pos=0. Keys ignored. tick && tcnt==GAP_TICKS-1 → SPAWN.
  - OVER: pos=0, game_over=1, score and misses frozen. start → clear score, misses and game_over, → SPAWN.
- start is ignored in SPAWN, ACTIVE, HIT_SHOW and GAP.
- misses never exceeds MAX_MISS.
- last_pos is not cleared on restart.

Decomposition:
- Shared package (`mole_pkg`):
  - State enum: IDLE, SPAWN, ACTIVE, HIT_SHOW, GAP, OVER.
  - Position constants: POS_NONE=0, POS_Q=1, POS_W=2, POS_E=3, POS_A=4, POS_S=5, POS_D=6, POS_Z=7, POS_X=8, POS_C=9.
  - Function `is_valid_pos(5b)`.
- One sub-module, `pos_lfsr`: clk, rst_n, seed parameter, 8-bit state output.
- FSM, counters and scoring stay in the top block.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, then release with no start for 20 cycles → pos=0, hit=0, score=0, misses=0, game_over=0, busy=0 throughout.
- Hit path (ACTIVE_TICKS=4, HIT_TICKS=2, GAP_TICKS=1): pulse start; when pos!=0, pulse key_valid with key_pos=pos.
  - Next cycle: hit=1, score=1, pos unchanged.
  - After 2 ticks: pos=0, hit=0.
  - After 1 more tick: new pos in 1..9 and different from the previous pos.
- Timeout path (same parameters): no keys → pos cleared on the 4th tick; misses 1, 2, 3 over three enemies; after the third miss game_over=1 and pos=0.
  - Pulse start → score=0, misses=0, game_over=0, pos!=0 within 20 cycles.
- Wrong key and collision: pos=5, key_pos=2 → misses+1, pos stays 5.
  - key_pos=0 or 12 → no change.
  - Correct key on the same cycle as the final timeout tick → hit=1, score+1, misses unchanged.
- Saturation and reset mid-game: force 260 hits → score=255.
  - Assert rst_n=0 during HIT_SHOW → next cycle all outputs at reset values.
- Spawn distribution: 1000 spawns → every position 1..9 occurs, pos never 10..15, and no two consecutive spawns share a position.
